// File: rtl/cpu_types_pkg.sv
// Shared CPU types: request-unit sequencer states.
package cpu_types_pkg;

  // 2'b11 is unused and is treated as HALTED by the request unit.
  typedef enum logic [1:0] {
    FETCH  = 2'b00,
    DATA   = 2'b01,
    HALTED = 2'b10
  } ru_state_t;

endpackage

// File: rtl/request_unit_if.sv
// Bundle of request-unit signals, with views for the unit and for a driver/monitor.
interface request_unit_if #(
  parameter int unsigned CNT_W = 32
) (
  input logic CLK
);
  logic             RST;
  logic             ihit;
  logic             dhit;
  logic             cu_dREN;
  logic             cu_dWEN;
  logic             cu_halt;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             pc_en;
  logic             halt;
  logic             bus_err;
  logic [CNT_W-1:0] stall_cnt;

  modport ru (
    input  CLK, RST, ihit, dhit, cu_dREN, cu_dWEN, cu_halt,
    output imemREN, dmemREN, dmemWEN, pc_en, halt, bus_err, stall_cnt
  );

  modport tb (
    input  CLK, imemREN, dmemREN, dmemWEN, pc_en, halt, bus_err, stall_cnt,
    output RST, ihit, dhit, cu_dREN, cu_dWEN, cu_halt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);
  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign q = cnt_q;
endmodule

// File: rtl/request_unit.sv
// Memory-request sequencer: fetch, optional data access, halt latch, timeout guard.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 0,
  parameter int unsigned TO_W    = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             halt,
  output logic             bus_err,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  ru_state_t       state_q, state_d;
  logic            op_rd_q, op_rd_d;
  logic            op_wr_q, op_wr_d;
  logic            bus_err_q, bus_err_d;
  logic [TO_W-1:0] wait_cnt;
  logic            in_fetch, in_data, waiting, timeout;

  assign in_fetch = (state_q == FETCH);
  assign in_data  = (state_q == DATA);
  assign waiting  = (in_fetch & ~ihit) | (in_data & ~dhit);
  assign timeout  = (TIMEOUT != 0) && waiting && (wait_cnt == TO_LAST);

  // Next-state, operand capture, timeout error and the Mealy PC strobe.
  always_comb begin
    state_d   = state_q;
    op_rd_d   = op_rd_q;
    op_wr_d   = op_wr_q;
    bus_err_d = bus_err_q;
    pc_en     = 1'b0;
    if (timeout) begin
      state_d   = HALTED;
      bus_err_d = 1'b1;
    end else if (in_fetch) begin
      if (ihit) begin
        if (cu_halt) begin
          state_d = HALTED;
        end else if (cu_dREN | cu_dWEN) begin
          state_d = DATA;
          op_wr_d = cu_dWEN;
          op_rd_d = cu_dREN & ~cu_dWEN;
        end else begin
          pc_en = 1'b1;
        end
      end
    end else if (in_data) begin
      if (dhit) begin
        state_d = FETCH;
        pc_en   = 1'b1;
      end
    end else begin
      // Also folds the unused encoding into HALTED.
      state_d = HALTED;
    end
    if (RST) pc_en = 1'b0;
  end

  // State and captured-access registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= FETCH;
      op_rd_q   <= 1'b0;
      op_wr_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_rd_q   <= op_rd_d;
      op_wr_q   <= op_wr_d;
      bus_err_q <= bus_err_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (1'b0),
    .inc (waiting),
    .q   (stall_cnt)
  );

  sat_counter #(.W(TO_W)) u_wait_cnt (
    .clk (CLK),
    .rst (RST),
    .clr (~waiting | timeout),
    .inc (waiting),
    .q   (wait_cnt)
  );

  assign imemREN = in_fetch;
  assign dmemREN = in_data & op_rd_q;
  assign dmemWEN = in_data & op_wr_q;
  assign halt    = ~in_fetch & ~in_data;
  assign bus_err = bus_err_q;
endmodule

// File: tb/tb_request_unit.sv
// Scoreboard bench: two request_unit instances (default and TIMEOUT=4/CNT_W=3)
// share stimulus; a transaction-level model predicts each cycle's outputs.
module tb_request_unit;
  logic CLK = 1'b0;
  logic RST, ihit, dhit, cu_dREN, cu_dWEN, cu_halt;

  logic        imem0, drd0, dwr0, pc0, hlt0, berr0;
  logic [31:0] stall0;
  logic        imem1, drd1, dwr1, pc1, hlt1, berr1;
  logic [2:0]  stall1;

  always #5 CLK = ~CLK;

  request_unit dut0 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .imemREN(imem0), .dmemREN(drd0), .dmemWEN(dwr0), .pc_en(pc0),
    .halt(hlt0), .bus_err(berr0), .stall_cnt(stall0)
  );

  request_unit #(.CNT_W(3), .TIMEOUT(4), .TO_W(16)) dut1 (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
    .cu_dREN(cu_dREN), .cu_dWEN(cu_dWEN), .cu_halt(cu_halt),
    .imemREN(imem1), .dmemREN(drd1), .dmemWEN(dwr1), .pc_en(pc1),
    .halt(hlt1), .bus_err(berr1), .stall_cnt(stall1)
  );

  typedef struct packed {
    logic        imem, drd, dwr, pc, hlt, berr;
    logic [31:0] stall;
  } exp_t;

  typedef struct packed {
    exp_t e0;
    exp_t e1;
  } pair_t;

  // Reference state: phase 0=instruction wait, 1=data access, 2=stopped.
  typedef struct {
    int     phase;
    bit     is_load, is_store, err;
    longint stalls;
    int     waited;
  } mdl_t;

  pair_t  sb[$];
  mdl_t   m0, m1;
  int     checks = 0;
  int     errors = 0;

  function automatic mdl_t mdl_reset();
    mdl_t r;
    r.phase = 0; r.is_load = 0; r.is_store = 0; r.err = 0;
    r.stalls = 0; r.waited = 0;
    return r;
  endfunction

  function automatic exp_t predict(mdl_t m, bit ih, bit dh, bit dr, bit dw, bit ch, bit rs);
    exp_t e;
    e.imem  = (m.phase == 0);
    e.drd   = (m.phase == 1) && m.is_load;
    e.dwr   = (m.phase == 1) && m.is_store;
    e.hlt   = (m.phase == 2);
    e.berr  = m.err;
    e.stall = 32'(m.stalls);
    e.pc    = !rs && (((m.phase == 0) && ih && !ch && !(dr || dw)) ||
                      ((m.phase == 1) && dh));
    return e;
  endfunction

  function automatic mdl_t advance(mdl_t m, bit ih, bit dh, bit dr, bit dw, bit ch, bit rs,
                                   int to, longint smax);
    mdl_t n = m;
    bit   stalled;
    if (rs) return mdl_reset();
    stalled = ((m.phase == 0) && !ih) || ((m.phase == 1) && !dh);
    if (stalled) begin
      if (m.stalls < smax) n.stalls = m.stalls + 1;
      if (to != 0 && m.waited == to - 1) begin
        n.phase = 2; n.err = 1; n.waited = 0;
      end else if (m.waited < 65535) begin
        n.waited = m.waited + 1;
      end
    end else begin
      n.waited = 0;
      if (m.phase == 0) begin
        if (ch) n.phase = 2;
        else if (dr || dw) begin
          n.phase = 1; n.is_store = dw; n.is_load = dr && !dw;
        end
      end else if (m.phase == 1) begin
        n.phase = 0;
      end
    end
    return n;
  endfunction

  task automatic cycle(input bit ih, dh, dr, dw, ch, rs);
    pair_t p;
    ihit = ih; dhit = dh; cu_dREN = dr; cu_dWEN = dw; cu_halt = ch; RST = rs;
    p.e0 = predict(m0, ih, dh, dr, dw, ch, rs);
    p.e1 = predict(m1, ih, dh, dr, dw, ch, rs);
    sb.push_back(p);
    m0 = advance(m0, ih, dh, dr, dw, ch, rs, 0, 64'hFFFF_FFFF);
    m1 = advance(m1, ih, dh, dr, dw, ch, rs, 4, 7);
    @(posedge CLK); #1;
  endtask

  task automatic cmp1(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input exp_t a, input exp_t e);
    cmp1({tag, ".imemREN"},   32'(a.imem), 32'(e.imem));
    cmp1({tag, ".dmemREN"},   32'(a.drd),  32'(e.drd));
    cmp1({tag, ".dmemWEN"},   32'(a.dwr),  32'(e.dwr));
    cmp1({tag, ".pc_en"},     32'(a.pc),   32'(e.pc));
    cmp1({tag, ".halt"},      32'(a.hlt),  32'(e.hlt));
    cmp1({tag, ".bus_err"},   32'(a.berr), 32'(e.berr));
    cmp1({tag, ".stall_cnt"}, a.stall,     e.stall);
  endtask

  // Monitor: one scoreboard entry per cycle, compared mid-cycle.
  initial begin
    pair_t p;
    exp_t  a0, a1;
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        p  = sb.pop_front();
        a0 = '{imem: imem0, drd: drd0, dwr: dwr0, pc: pc0, hlt: hlt0, berr: berr0,
               stall: stall0};
        a1 = '{imem: imem1, drd: drd1, dwr: dwr1, pc: pc1, hlt: hlt1, berr: berr1,
               stall: 32'(stall1)};
        cmp("d0", a0, p.e0);
        cmp("d1", a1, p.e1);
      end
    end
  end

  initial begin
    RST = 1'b1; ihit = 0; dhit = 0; cu_dREN = 0; cu_dWEN = 0; cu_halt = 0;
    @(posedge CLK); #1;
    m0 = mdl_reset();
    m1 = mdl_reset();

    // Reset state, then back-to-back non-memory instructions.
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 0, 0, 0, 0, 0);
    // Load with three dhit misses.
    cycle(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    // Both read and write requested: write wins.
    cycle(1, 0, 1, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0);
    // Halt with store: halt wins, later hits ignored.
    cycle(1, 0, 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 0, 0, 0);
    // Timeout on the constrained instance.
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0, 0);
    // Stall-count saturation with hits breaking up the waits.
    cycle(0, 0, 0, 0, 0, 1);
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0);
    end
    // Reset during the dhit cycle of a load.
    cycle(0, 0, 0, 0, 0, 1);
    cycle(1, 0, 1, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 1);
    cycle(0, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      bit rs;
      if (m0.phase == 2 && m1.phase == 2) rs = ($urandom_range(3) == 0);
      else if (m1.phase == 2)             rs = ($urandom_range(15) == 0);
      else                                rs = ($urandom_range(199) == 0);
      cycle($urandom_range(9) < 6, $urandom_range(9) < 6,
            $urandom_range(3) == 0, $urandom_range(3) == 0,
            $urandom_range(31) == 0, rs);
    end

    @(negedge CLK); #1;
    cmp1("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
